chi_lite_home_ctrl: RTL and testbench

Home-node coherence controller that sits directly upstream of the CHI-lite directory RAM (`chi_lite_directory`). It accepts one coherence request at a time and reads the line's directory entry. It then issues the required snoops serially, waits for each snoop response, writes the updated state and sharer vector back, and returns a completion to the requester. It is the only master of the directory's read/write port.

---
 rtl/chi_lite_pkg.sv | 49 ++++
 rtl/chi_lite_lsb_find.sv | 22 ++
 rtl/chi_lite_home_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_chi_lite_home_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chi_lite_pkg.sv
// rtl/chi_lite_pkg.sv - shared types for the CHI-lite home-node controller
package chi_lite_pkg;

  localparam int NODE_W = 6;

  typedef enum logic [7:0] {
    DIR_I  = 8'd0,
    DIR_S  = 8'd1,
    DIR_UC = 8'd2
  } dir_state_e;

  typedef enum logic [1:0] {
    REQ_READ_SHARED = 2'd0,
    REQ_READ_UNIQUE = 2'd1,
    REQ_EVICT       = 2'd2,
    REQ_RSVD        = 2'd3
  } req_op_e;

  typedef enum logic {
    SNP_SHARED = 1'b0,
    SNP_UNIQUE = 1'b1
  } snp_op_e;

  typedef enum logic [1:0] {
    RSP_COMP_DATA_SC = 2'd0,
    RSP_COMP_DATA_UC = 2'd1,
    RSP_COMP         = 2'd2,
    RSP_ERR          = 2'd3
  } rsp_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_SNOOP,
    ST_WAIT_SRSP,
    ST_UPDATE,
    ST_RESPOND
  } ctrl_state_e;

  // Unknown encodings in the directory are treated as invalid lines.
  function automatic dir_state_e dir_decode(input logic [7:0] raw);
    case (raw)
      8'd1:    dir_decode = DIR_S;
      8'd2:    dir_decode = DIR_UC;
      default: dir_decode = DIR_I;
    endcase
  endfunction

endpackage

// File: rtl/chi_lite_lsb_find.sv
// rtl/chi_lite_lsb_find.sv - lowest-set-bit finder over the sharer vector
module chi_lite_lsb_find #(
  parameter int NODES = 64,
  parameter int IDX_W = 6
) (
  input  logic [NODES-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chi_lite_home_ctrl.sv
// rtl/chi_lite_home_ctrl.sv - home-node controller: directory lookup, serial snoops, write-back, completion
module chi_lite_home_ctrl
  import chi_lite_pkg::*;
#(
  parameter int LINES = 1024,
  parameter int NODES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [NODE_W-1:0] req_src,
  input  logic [31:0]       req_index,
  output logic              snp_valid,
  input  logic              snp_ready,
  output logic              snp_op,
  output logic [NODE_W-1:0] snp_tgt,
  output logic [31:0]       snp_index,
  input  logic              snprsp_valid,
  input  logic [NODE_W-1:0] snprsp_src,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [NODE_W-1:0] rsp_tgt,
  output logic [31:0]       rsp_index,
  output logic              dir_rd_en,
  output logic              dir_wr_en,
  output logic [31:0]       dir_index,
  output logic [7:0]        dir_state_in,
  output logic [NODES-1:0]  dir_sharers_in,
  input  logic [7:0]        dir_state_out,
  input  logic [NODES-1:0]  dir_sharers_out,
  output logic              busy
);

  ctrl_state_e       state_q, state_d;
  req_op_e           op_q;
  logic [NODE_W-1:0] src_q;
  logic [31:0]       index_q;
  logic [NODES-1:0]  mask_q, mask_d;
  dir_state_e        new_state_q;
  logic [NODES-1:0]  new_sharers_q;
  rsp_op_e           rsp_op_q;
  snp_op_e           snp_op_q;
  logic [NODE_W-1:0] snp_tgt_q;

  logic [NODES-1:0]  src_oh, tgt_oh;
  dir_state_e        cur_state, lk_state;
  logic [NODES-1:0]  lk_mask, lk_sharers;
  rsp_op_e           lk_rsp;
  snp_op_e           lk_snp;
  logic              lk_err;
  logic              srsp_hit;
  logic [NODE_W-1:0] next_tgt;
  logic              next_found;

  assign src_oh   = NODES'(1) << src_q;
  assign tgt_oh   = NODES'(1) << snp_tgt_q;
  assign srsp_hit = snprsp_valid && (snprsp_src == snp_tgt_q);

  // Transition rules evaluated against the combinational directory read in LOOKUP.
  always_comb begin
    cur_state  = dir_decode(dir_state_out);
    lk_err     = (index_q >= 32'(LINES)) || (op_q == REQ_RSVD);
    lk_mask    = '0;
    lk_state   = cur_state;
    lk_sharers = dir_sharers_out;
    lk_rsp     = RSP_ERR;
    lk_snp     = SNP_SHARED;
    case (op_q)
      REQ_READ_SHARED: begin
        if (cur_state == DIR_UC && dir_sharers_out == src_oh) begin
          lk_rsp = RSP_COMP_DATA_UC;
        end else begin
          if (cur_state == DIR_UC) lk_mask = dir_sharers_out;
          lk_state   = DIR_S;
          lk_sharers = dir_sharers_out | src_oh;
          lk_rsp     = RSP_COMP_DATA_SC;
        end
      end
      REQ_READ_UNIQUE: begin
        lk_mask    = dir_sharers_out & ~src_oh;
        lk_snp     = SNP_UNIQUE;
        lk_state   = DIR_UC;
        lk_sharers = src_oh;
        lk_rsp     = RSP_COMP_DATA_UC;
      end
      REQ_EVICT: begin
        lk_sharers = dir_sharers_out & ~src_oh;
        lk_state   = (lk_sharers == '0) ? DIR_I : cur_state;
        lk_rsp     = RSP_COMP;
      end
      default: ;
    endcase
    if (lk_err) begin
      lk_mask = '0;
      lk_rsp  = RSP_ERR;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (state_q == ST_LOOKUP) begin
      mask_d = lk_mask;
    end else if (state_q == ST_WAIT_SRSP && srsp_hit) begin
      mask_d = mask_q & ~tgt_oh;
    end
  end

  chi_lite_lsb_find #(
    .NODES(NODES),
    .IDX_W(NODE_W)
  ) u_lsb_find (
    .vec  (mask_d),
    .idx  (next_tgt),
    .found(next_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    snp_valid = 1'b0;
    rsp_valid = 1'b0;
    dir_rd_en = 1'b0;
    dir_wr_en = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        dir_rd_en = 1'b1;
        if (lk_err)          state_d = ST_RESPOND;
        else if (next_found) state_d = ST_SNOOP;
        else                 state_d = ST_UPDATE;
      end
      ST_SNOOP: begin
        snp_valid = 1'b1;
        if (snp_ready) state_d = ST_WAIT_SRSP;
      end
      ST_WAIT_SRSP: begin
        if (srsp_hit) state_d = next_found ? ST_SNOOP : ST_UPDATE;
      end
      ST_UPDATE: begin
        dir_wr_en = 1'b1;
        state_d   = ST_RESPOND;
      end
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= REQ_READ_SHARED;
      src_q         <= '0;
      index_q       <= '0;
      mask_q        <= '0;
      new_state_q   <= DIR_I;
      new_sharers_q <= '0;
      rsp_op_q      <= RSP_COMP_DATA_SC;
      snp_op_q      <= SNP_SHARED;
      snp_tgt_q     <= '0;
    end else begin
      mask_q <= mask_d;
      if (state_q == ST_IDLE && req_valid) begin
        op_q    <= req_op_e'(req_op);
        src_q   <= req_src;
        index_q <= req_index;
      end
      if (state_q == ST_LOOKUP) begin
        new_state_q   <= lk_state;
        new_sharers_q <= lk_sharers;
        rsp_op_q      <= lk_rsp;
        snp_op_q      <= lk_snp;
      end
      // Target only moves on entry to SNOOP, so it is stable while snp_valid waits.
      if (state_d == ST_SNOOP) snp_tgt_q <= next_tgt;
    end
  end

  assign snp_op         = snp_op_q;
  assign snp_tgt        = snp_tgt_q;
  assign snp_index      = index_q;
  assign rsp_op         = rsp_op_q;
  assign rsp_tgt        = src_q;
  assign rsp_index      = index_q;
  assign dir_index      = index_q;
  assign dir_state_in   = new_state_q;
  assign dir_sharers_in = new_sharers_q;

endmodule

// File: tb/tb_chi_lite_home_ctrl.sv
// tb/tb_chi_lite_home_ctrl.sv - directed and randomized bench for chi_lite_home_ctrl against a transaction model
module tb_chi_lite_home_ctrl;

  localparam int LINES = 1024;
  localparam int NODES = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [5:0]  req_src = 6'd0;
  logic [31:0] req_index = 32'd0;
  logic        snp_valid;
  logic        snp_ready = 1'b0;
  logic        snp_op;
  logic [5:0]  snp_tgt;
  logic [31:0] snp_index;
  logic        snprsp_valid = 1'b0;
  logic [5:0]  snprsp_src = 6'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_op;
  logic [5:0]  rsp_tgt;
  logic [31:0] rsp_index;
  logic        dir_rd_en;
  logic        dir_wr_en;
  logic [31:0] dir_index;
  logic [7:0]  dir_state_in;
  logic [63:0] dir_sharers_in;
  logic [7:0]  dir_state_out;
  logic [63:0] dir_sharers_out;
  logic        busy;

  chi_lite_home_ctrl #(.LINES(LINES), .NODES(NODES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_src(req_src), .req_index(req_index),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_tgt(snp_tgt), .snp_index(snp_index),
    .snprsp_valid(snprsp_valid), .snprsp_src(snprsp_src),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_tgt(rsp_tgt), .rsp_index(rsp_index),
    .dir_rd_en(dir_rd_en), .dir_wr_en(dir_wr_en), .dir_index(dir_index),
    .dir_state_in(dir_state_in), .dir_sharers_in(dir_sharers_in),
    .dir_state_out(dir_state_out), .dir_sharers_out(dir_sharers_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Directory RAM the DUT talks to, plus the model's own copy of the directory.
  logic [7:0]  ram_state [LINES];
  logic [63:0] ram_sh    [LINES];
  logic [7:0]  m_state   [LINES];
  logic [63:0] m_sh      [LINES];

  assign dir_state_out   = (dir_index < 32'(LINES)) ? ram_state[dir_index[9:0]] : 8'h0;
  assign dir_sharers_out = (dir_index < 32'(LINES)) ? ram_sh[dir_index[9:0]]    : 64'h0;

  int tick = 0;
  always @(posedge clk) begin
    tick <= tick + 1;
    if (dir_wr_en && dir_index < 32'(LINES)) begin
      ram_state[dir_index[9:0]] = dir_state_in;
      ram_sh[dir_index[9:0]]    = dir_sharers_in;
    end
  end

  int          wr_cnt = 0;
  int          wr_tick = 0;
  int          overlap = 0;
  logic [7:0]  wr_st;
  logic [63:0] wr_sh;
  always @(negedge clk) begin
    if (dir_wr_en) begin
      wr_cnt  = wr_cnt + 1;
      wr_tick = tick;
      wr_st   = dir_state_in;
      wr_sh   = dir_sharers_in;
    end
    if (dir_rd_en && dir_wr_en) overlap = overlap + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {snp_valid, rsp_valid, dir_rd_en, dir_wr_en, busy}, 64'h0);
    chk({tag, "_snp"}, {snp_op, snp_tgt, snp_index}, 64'h0);
    chk({tag, "_rsp"}, {rsp_op, rsp_tgt, rsp_index}, 64'h0);
    chk({tag, "_dir_index"}, dir_index, 64'h0);
    chk({tag, "_dir_state_in"}, dir_state_in, 64'h0);
    chk({tag, "_dir_sharers_in"}, dir_sharers_in, 64'h0);
  endtask

  task automatic set_entry(input int idx, input logic [7:0] st, input logic [63:0] sh);
    ram_state[idx] = st;  ram_sh[idx] = sh;
    m_state[idx]   = st;  m_sh[idx]   = sh;
  endtask

  // Transaction-level reference: expected snoop list in ascending node order, new entry, completion.
  bit          m_err;
  int          m_rsp;
  int          m_snp_op;
  logic [7:0]  m_nst;
  logic [63:0] m_nsh;
  int          exp_q[$];

  function automatic void ref_model(input int op, input int src, input int idx);
    logic [63:0] s, sh;
    logic [7:0]  st;
    s = 64'd1 << src;
    exp_q.delete();
    m_err = (idx >= LINES) || (op == 3);
    m_snp_op = 0; m_rsp = 3; m_nst = 8'd0; m_nsh = 64'd0;
    if (m_err) return;
    sh = m_sh[idx];
    st = (m_state[idx] == 8'd1 || m_state[idx] == 8'd2) ? m_state[idx] : 8'd0;
    case (op)
      0: begin
        if (st == 8'd2 && sh == s) begin
          m_nst = st; m_nsh = sh; m_rsp = 1;
        end else begin
          if (st == 8'd2) for (int n = 0; n < NODES; n++) if (sh[n]) exp_q.push_back(n);
          m_nst = 8'd1; m_nsh = sh | s; m_rsp = 0;
        end
      end
      1: begin
        for (int n = 0; n < NODES; n++) if (sh[n] && n != src) exp_q.push_back(n);
        m_snp_op = 1; m_nst = 8'd2; m_nsh = s; m_rsp = 1;
      end
      default: begin
        m_nsh = sh & ~s;
        m_nst = (m_nsh == 64'd0) ? 8'd0 : st;
        m_rsp = 2;
      end
    endcase
  endfunction

  // Called and returns at a falling edge; drives one full request through to completion.
  task automatic run_txn(input int op, input int src, input int idx, input int hold_first, input int bogus_src);
    int          t0, rsp_tick, n_snp, guard, hold, e;
    logic [5:0]  tgt;
    logic [41:0] rsp_snap;
    ref_model(op, src, idx);
    wr_cnt = 0;
    req_valid = 1'b1; req_op = 2'(op); req_src = 6'(src); req_index = 32'(idx);
    chk("req_ready_idle", req_ready, 1);
    t0 = tick;
    @(negedge clk);
    req_valid = 1'b0;
    chk("lookup_rd_en", dir_rd_en, 1);
    chk("lookup_index", dir_index, 64'(idx));
    n_snp = 0; guard = 0;
    while (!rsp_valid && guard < 400) begin
      if (snp_valid) begin
        tgt = snp_tgt;
        chk("snp_expected", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("snp_tgt", tgt, 64'(e));
        chk("snp_op", snp_op, 64'(m_snp_op));
        chk("snp_index", snp_index, 64'(idx));
        hold = (n_snp == 0) ? hold_first : $urandom_range(0, 1);
        repeat (hold) begin
          @(negedge clk); guard++;
          chk("snp_hold_valid", snp_valid, 1);
          chk("snp_hold_tgt", snp_tgt, tgt);
        end
        snp_ready = 1'b1;
        @(negedge clk); guard++;
        snp_ready = 1'b0;
        chk("snp_dropped", snp_valid, 0);
        if (bogus_src >= 0 && bogus_src != int'(tgt) && n_snp == 0) begin
          snprsp_valid = 1'b1; snprsp_src = 6'(bogus_src);
          @(negedge clk); guard++;
          snprsp_valid = 1'b0;
          chk("bogus_srsp_ignored", {busy, snp_valid, rsp_valid, dir_wr_en}, 4'b1000);
        end
        repeat ($urandom_range(0, 2)) begin @(negedge clk); guard++; end
        snprsp_valid = 1'b1; snprsp_src = tgt;
        @(negedge clk); guard++;
        snprsp_valid = 1'b0;
        n_snp++;
      end else begin
        @(negedge clk); guard++;
      end
    end
    chk("rsp_seen", rsp_valid, 1);
    rsp_tick = tick;
    chk("rsp_op", rsp_op, 64'(m_rsp));
    chk("rsp_tgt", rsp_tgt, 64'(src));
    chk("rsp_index", rsp_index, 64'(idx));
    chk("snoops_left", exp_q.size(), 0);
    if (m_err) chk("err_rsp_cycle", rsp_tick - t0, 2);
    else if (n_snp == 0) begin
      chk("wr_cycle", wr_tick - t0, 2);
      chk("rsp_cycle", rsp_tick - t0, 3);
    end
    rsp_snap = {rsp_valid, rsp_op, rsp_tgt, rsp_index, 1'b0};
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("rsp_stable", {rsp_valid, rsp_op, rsp_tgt, rsp_index, 1'b0}, rsp_snap);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_rsp", {req_ready, busy}, 2'b10);
    chk("wr_count", wr_cnt, m_err ? 0 : 1);
    if (!m_err) begin
      chk("wr_state", wr_st, m_nst);
      chk("wr_sharers", wr_sh, m_nsh);
      m_state[idx] = m_nst;
      m_sh[idx]    = m_nsh;
    end
    if (idx < LINES) begin
      chk("ram_state", ram_state[idx], m_state[idx]);
      chk("ram_sharers", ram_sh[idx], m_sh[idx]);
    end
  endtask

  initial begin
    int guard, wr_before, r, op, idx, k;
    for (int i = 0; i < LINES; i++) begin
      ram_state[i] = 8'd0; ram_sh[i] = 64'd0; m_state[i] = 8'd0; m_sh[i] = 64'd0;
    end
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {req_ready, busy}, 2'b10);

    set_entry(5, 8'd0, 64'h0);   run_txn(0, 3, 5, 0, -1);
    run_txn(1, 0, 5, 0, -1);
    set_entry(7, 8'd2, 64'h4);   run_txn(0, 4, 7, 0, 9);
    set_entry(9, 8'd1, 64'h0F);  run_txn(1, 1, 9, 3, -1);
    set_entry(7, 8'd2, 64'h4);   run_txn(2, 2, 7, 0, -1);
    run_txn(0, 1, 1024, 0, -1);
    set_entry(11, 8'd2, 64'h20); run_txn(0, 5, 11, 0, -1);
    run_txn(3, 2, 11, 0, -1);
    set_entry(12, 8'd1, 64'h6);  run_txn(2, 0, 12, 0, -1);

    // Reset while a snoop response is outstanding.
    set_entry(7, 8'd2, 64'h4);
    wr_cnt = 0;
    req_valid = 1'b1; req_op = 2'd0; req_src = 6'd4; req_index = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!snp_valid && guard < 20) begin @(negedge clk); guard++; end
    chk("rst_test_snoop", snp_valid, 1);
    snp_ready = 1'b1;
    @(negedge clk);
    snp_ready = 1'b0;
    chk("rst_test_waiting", {busy, snp_valid}, 2'b10);
    wr_before = wr_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", {req_ready, busy}, 2'b10);
    repeat (3) @(negedge clk);
    chk("no_write_on_reset", wr_cnt, wr_before);
    chk("entry_kept_state", ram_state[7], 8'd2);
    chk("entry_kept_sharers", ram_sh[7], 64'h4);

    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       set_entry(i, 8'd0, 64'h0);
        1:       set_entry(i, 8'd1, 64'($urandom_range(1, 255)));
        2:       set_entry(i, 8'd2, 64'd1 << $urandom_range(0, 7));
        default: set_entry(i, 8'd7, 64'h0);
      endcase
    end
    for (int t = 0; t < 80; t++) begin
      r   = $urandom_range(0, 15);
      op  = (r < 5) ? 0 : (r < 10) ? 1 : (r < 15) ? 2 : 3;
      idx = ($urandom_range(0, 19) == 0) ? LINES + $urandom_range(0, 5) : $urandom_range(0, 15);
      run_txn(op, $urandom_range(0, 7), idx, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : -1);
    end

    chk("rd_wr_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
